corescore_pkt_fifo: RTL and testbench

//  Byte-wide AXI-Stream FIFO carrying tdata+tlast, inserted between corescorecore (producer)
//  and the UART emitter (consumer) in the corescore board tops. Absorbs producer bursts while
//  the emitter serialises at UART rate. Optionally holds output until whole tlast-terminated

---
 rtl/corescore_pkt_fifo.sv | 115 +++++++++++
 tb/tb_corescore_pkt_fifo.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/corescore_pkt_fifo.sv
// corescore_pkt_fifo: byte-wide AXI-Stream FIFO ({tlast, tdata}) between the
// corescore producer and the UART emitter. First-word fall-through output.
// Optional store-and-forward mode, enabled by defining CORESCORE_PKT_FIFO_SAF_EN:
// output is held until a whole tlast-terminated packet is stored. If the FIFO
// fills with no complete packet, it falls back to cut-through until the next
// tlast byte leaves.
`timescale 1ns/1ps

module corescore_pkt_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [7:0]            i_tdata,
    input  logic                  i_tlast,
    input  logic                  i_tvalid,
    output logic                  o_tready,
    output logic [7:0]            o_tdata,
    output logic                  o_tlast,
    output logic                  o_tvalid,
    input  logic                  i_tready,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic [DEPTH_LOG2:0]   o_pkt_count
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [8:0]            mem [DEPTH];
    logic [DEPTH_LOG2:0]   wr_ptr;
    logic [DEPTH_LOG2:0]   rd_ptr;
    logic [DEPTH_LOG2:0]   level;
    logic [DEPTH_LOG2:0]   level_next;
    logic                  tready_q;
    logic                  wr;
    logic                  rd;
    logic [8:0]            head;

    assign wr       = i_tvalid && tready_q;
    assign rd       = o_tvalid && i_tready;
    assign head     = mem[rd_ptr[DEPTH_LOG2-1:0]];
    assign o_tdata  = head[7:0];
    assign o_tlast  = head[8];
    assign o_tready = tready_q;
    assign o_level  = level;

    // Occupancy after this cycle's handshakes.
    always_comb begin
        level_next = level;
        if (wr && !rd) begin
            level_next = level + 1'b1;
        end else if (!wr && rd) begin
            level_next = level - 1'b1;
        end
    end

    // Storage write; entries are not reset, pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (!i_rst && wr) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= {i_tlast, i_tdata};
        end
    end

    // Pointers, level and the registered ready. level never exceeds DEPTH, so
    // its MSB is set exactly when full; ready is the inverse for the next level.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            tready_q <= 1'b0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (rd) rd_ptr <= rd_ptr + 1'b1;
            level    <= level_next;
            tready_q <= ~level_next[DEPTH_LOG2];
        end
    end

`ifdef CORESCORE_PKT_FIFO_SAF_EN
    logic [DEPTH_LOG2:0]   pkt_count;
    logic                  rel_q;
    logic                  pkt_in;
    logic                  pkt_out;

    assign pkt_in      = wr && i_tlast;
    assign pkt_out     = rd && head[8];
    assign o_pkt_count = pkt_count;
    assign o_tvalid    = (level != '0) && ((pkt_count != '0) || rel_q);

    // Complete-packet count and the oversize-packet release flag. A tlast
    // entry can only be read while pkt_count is nonzero, so set and clear
    // of the release flag never coincide.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pkt_count <= '0;
            rel_q     <= 1'b0;
        end else begin
            if (pkt_in && !pkt_out) begin
                pkt_count <= pkt_count + 1'b1;
            end else if (!pkt_in && pkt_out) begin
                pkt_count <= pkt_count - 1'b1;
            end
            if (level[DEPTH_LOG2] && (pkt_count == '0)) begin
                rel_q <= 1'b1;
            end else if (pkt_out) begin
                rel_q <= 1'b0;
            end
        end
    end
`else
    assign o_tvalid    = (level != '0);
    assign o_pkt_count = '0;
`endif

endmodule

// File: tb/tb_corescore_pkt_fifo.sv
// Bench for corescore_pkt_fifo: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
`timescale 1ns/1ps

module tb_corescore_pkt_fifo;

    localparam int DL    = 4;
    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   i_tdata = '0;
    logic         i_tlast = 1'b0;
    logic         i_tvalid = 1'b0;
    logic         i_tready = 1'b0;
    logic         o_tready;
    logic [7:0]   o_tdata;
    logic         o_tlast;
    logic         o_tvalid;
    logic [DL:0]  o_level;
    logic [DL:0]  o_pkt_count;

    int checks = 0;
    int failures = 0;

    corescore_pkt_fifo #(.DEPTH_LOG2(DL)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .o_tready(o_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .i_tready(i_tready),
        .o_level(o_level), .o_pkt_count(o_pkt_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    byte unsigned mq_data[$];
    bit           mq_last[$];
    bit           m_rel = 0;
    bit           m_rdy = 0;
    bit           mvalid = 0;
    bit           m_wr, m_rd, m_pl, m_fnp;
    byte unsigned dut_in[$];
    byte unsigned dut_out[$];
    bit           t6_active = 0;
    bit           t6_seen = 0;

    function automatic int m_pkt();
        int n = 0;
`ifdef CORESCORE_PKT_FIFO_SAF_EN
        foreach (mq_last[i]) if (mq_last[i]) n++;
`endif
        return n;
    endfunction

    function automatic bit m_vld();
`ifdef CORESCORE_PKT_FIFO_SAF_EN
        return (mq_data.size() != 0) && (m_pkt() != 0 || m_rel);
`else
        return mq_data.size() != 0;
`endif
    endfunction

    // Compare on the falling edge, then advance the model across the next rising edge.
    always @(negedge clk) begin
        if (mvalid) begin
            chk("tready", o_tready, m_rdy);
            chk("tvalid", o_tvalid, m_vld());
            chk("level", o_level, mq_data.size());
            chk("pkt_count", o_pkt_count, m_pkt());
            if (m_vld()) begin
                chk("tdata", o_tdata, mq_data[0]);
                chk("tlast", o_tlast, mq_last[0]);
            end
        end
        if (t6_active && !t6_seen && o_tvalid) begin
            t6_seen = 1;
            chk("saf_release_level", o_level, 16);
        end
        if (!rst) begin
            if (o_tvalid && i_tready) dut_out.push_back(o_tdata);
            if (i_tvalid && o_tready) dut_in.push_back(i_tdata);
        end
        if (rst) begin
            mq_data.delete();
            mq_last.delete();
            m_rel  = 0;
            m_rdy  = 0;
            mvalid = 1;
        end else if (mvalid) begin
            m_wr  = i_tvalid && m_rdy;
            m_rd  = m_vld() && i_tready;
            m_pl  = m_rd && mq_last[0];
            m_fnp = (mq_data.size() == DEPTH) && (m_pkt() == 0);
            if (m_rd) begin
                void'(mq_data.pop_front());
                void'(mq_last.pop_front());
            end
            if (m_wr) begin
                mq_data.push_back(i_tdata);
                mq_last.push_back(i_tlast);
            end
`ifdef CORESCORE_PKT_FIFO_SAF_EN
            if (m_fnp) m_rel = 1;
            else if (m_pl) m_rel = 0;
`endif
            m_rdy = mq_data.size() < DEPTH;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input byte unsigned d, input bit l);
        int n = 0;
        i_tdata  = d;
        i_tlast  = l;
        i_tvalid = 1;
        while (!o_tready && n < 100) begin
            step();
            n++;
        end
        if (n == 100) chk("push_timeout", 0, 1);
        step();
        i_tvalid = 0;
        i_tlast  = 0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        i_tready = 1;
        while (o_level != 0 && n < 200) begin
            step();
            n++;
        end
        chk(nm, (n < 200) ? 1 : 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int bad;
        bit acc;

        // 1: reset then idle
        rst = 1;
        step();
        step();
        chk("t1_tready_in_reset", o_tready, 0);
        chk("t1_tvalid_in_reset", o_tvalid, 0);
        rst = 0;
        step();
        chk("t1_tready_after", o_tready, 1);
        chk("t1_tvalid_after", o_tvalid, 0);
        chk("t1_level_after", o_level, 0);

        // 2: single byte, first-word fall-through latency
        i_tready = 1;
        i_tdata  = 8'h41;
        i_tlast  = 1;
        i_tvalid = 1;
        step();
        i_tvalid = 0;
        i_tlast  = 0;
        chk("t2_tvalid", o_tvalid, 1);
        chk("t2_tdata", o_tdata, 8'h41);
        chk("t2_tlast", o_tlast, 1);
        step();
        chk("t2_level", o_level, 0);
        chk("t2_tvalid_after", o_tvalid, 0);

        // 3: fill to full, 17th waits, then drains in order
        i_tready = 0;
        dut_out.delete();
        for (int i = 0; i < 16; i++) begin
            i_tdata  = 8'(i);
            i_tlast  = 0;
            i_tvalid = 1;
            step();
        end
        chk("t3_tready_full", o_tready, 0);
        chk("t3_level_full", o_level, 16);
        i_tdata = 8'h10;
        i_tlast = 1;
        step();
        step();
        chk("t3_level_hold", o_level, 16);
        chk("t3_tdata_hold", o_tdata, 8'h00);
        i_tready = 1;
        step();
        chk("t3_level_first_pop", o_level, 15);
        chk("t3_tready_reopen", o_tready, 1);
        step();
        chk("t3_level_17th_in", o_level, 15);
        i_tvalid = 0;
        i_tlast  = 0;
        drain("t3_drain");
        chk("t3_out_count", dut_out.size(), 17);
        bad = 0;
        foreach (dut_out[i]) if (dut_out[i] != 8'(i)) bad++;
        chk("t3_out_order", bad, 0);

        // 4: random traffic with pointer wrap
        dut_out.delete();
        cnt = 0;
        for (int c = 0; c < 10000; c++) begin
            i_tvalid = 1'($urandom_range(0, 1));
            i_tdata  = 8'(cnt);
            i_tlast  = ($urandom_range(0, 4) == 0);
            i_tready = 1'($urandom_range(0, 1));
            acc = i_tvalid && o_tready;
            step();
            if (acc) cnt++;
        end
        i_tdata = 8'(cnt);
        i_tlast = 1;
        push(8'(cnt), 1);
        cnt++;
        drain("t4_drain");
        chk("t4_out_count", dut_out.size(), cnt);
        bad = 0;
        foreach (dut_out[i]) if (dut_out[i] != 8'(i)) bad++;
        chk("t4_out_order", bad, 0);

`ifdef CORESCORE_PKT_FIFO_SAF_EN
        // 5: store-and-forward holds until tlast
        i_tready = 1;
        push(8'h6F, 0);
        chk("t5_hold_a", o_tvalid, 0);
        step();
        chk("t5_hold_b", o_tvalid, 0);
        chk("t5_pkt_0", o_pkt_count, 0);
        push(8'h6B, 1);
        chk("t5_tvalid", o_tvalid, 1);
        chk("t5_tdata_o", o_tdata, 8'h6F);
        chk("t5_pkt_1", o_pkt_count, 1);
        step();
        chk("t5_tdata_k", o_tdata, 8'h6B);
        chk("t5_tlast_k", o_tlast, 1);
        step();
        chk("t5_pkt_after", o_pkt_count, 0);
        chk("t5_level_after", o_level, 0);

        // 6: oversize packet escapes via release
        dut_out.delete();
        t6_active = 1;
        for (int i = 0; i < 20; i++) push(8'(8'h80 + i), i == 19);
        drain("t6_drain");
        t6_active = 0;
        chk("t6_release_seen", t6_seen, 1);
        chk("t6_out_count", dut_out.size(), 20);
        bad = 0;
        foreach (dut_out[i]) if (dut_out[i] != 8'(8'h80 + i)) bad++;
        chk("t6_out_order", bad, 0);
        push(8'h55, 0);
        step();
        step();
        chk("t6_release_cleared", o_tvalid, 0);
`endif

        // 7: reset with data stored
        i_tready = 0;
        for (int i = 0; i < 5; i++) push(8'(8'hA0 + i), i == 2);
        rst = 1;
        step();
        chk("t7_tvalid", o_tvalid, 0);
        chk("t7_level", o_level, 0);
        chk("t7_pkt", o_pkt_count, 0);
        chk("t7_tready", o_tready, 0);
        rst = 0;
        step();
        chk("t7_tready_after", o_tready, 1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
